rca_result_buffer: RTL

RCA_RESULT_BUFFER -- requirements
Module: rca_result_buffer

---
 rtl/rca_result_buffer_pkg.sv | 17 +
 rtl/rca_result_buffer_if.sv | 33 +++
 rtl/rca_result_fifo.sv | 67 ++++++
 rtl/rca_result_buffer.sv | 64 ++++++
 4 files changed

// File: rtl/rca_result_buffer_pkg.sv
// Shared types and configuration for the RCA result buffer: id type,
// result port geometry and the default buffer depth.
package rca_result_buffer_pkg;

   localparam int XLEN                 = 32;
   localparam int NUM_WRITE_PORTS      = 2;
   localparam int ID_W                 = 4;
   localparam int RCA_RESULT_BUF_DEPTH = 4;

   typedef logic [ID_W-1:0] id_t;

   // Occupancy needs one extra bit so that "full" (count == DEPTH) is representable.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/rca_result_buffer_if.sv
// Result-offer and writeback channels of the RCA result buffer, plus flush
// and occupancy. The buffer uses the slave modport, its environment the master.
interface rca_result_buffer_if
   import rca_result_buffer_pkg::*;
#(
   parameter int DEPTH    = RCA_RESULT_BUF_DEPTH,
   parameter int WIDTH_RD = NUM_WRITE_PORTS * XLEN
) ();

   localparam int CNT_W = cnt_w(DEPTH);

   logic                flush;
   logic                res_valid;
   id_t                 res_id;
   logic [WIDTH_RD-1:0] res_rd;
   logic                res_ready;
   logic                wb_done;
   id_t                 wb_id;
   logic [WIDTH_RD-1:0] wb_rd;
   logic                wb_ack;
   logic [CNT_W-1:0]    count;

   modport slave (
      input  flush, res_valid, res_id, res_rd, wb_ack,
      output res_ready, wb_done, wb_id, wb_rd, count
   );

   modport master (
      output flush, res_valid, res_id, res_rd, wb_ack,
      input  res_ready, wb_done, wb_id, wb_rd, count
   );

endinterface

// File: rtl/rca_result_fifo.sv
// Circular result store: id/data memory with wrapping read/write pointers and
// an occupancy counter. Memory contents are never reset.
module rca_result_fifo
   import rca_result_buffer_pkg::*;
#(
   parameter int DEPTH    = RCA_RESULT_BUF_DEPTH,
   parameter int WIDTH_RD = NUM_WRITE_PORTS * XLEN,
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int CNT_W   = cnt_w(DEPTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                push,
   input  id_t                 push_id,
   input  logic [WIDTH_RD-1:0] push_rd,
   input  logic                pop,
   output logic                full,
   output logic                empty,
   output id_t                 head_id,
   output logic [WIDTH_RD-1:0] head_rd,
   output logic [CNT_W-1:0]    count
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("rca_result_fifo: DEPTH must be a power of two and at least 2");
   end

   id_t                 id_mem [DEPTH];
   logic [WIDTH_RD-1:0] rd_mem [DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic                do_push;
   logic                do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head_id = id_mem[rd_ptr];
   assign head_rd = rd_mem[rd_ptr];

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         id_mem[wr_ptr] <= push_id;
         rd_mem[wr_ptr] <= push_rd;
      end
   end

endmodule

// File: rtl/rca_result_buffer.sv
// RCA result buffer: queues core results for CPU writeback with flush and,
// when RCA_RESULT_BYPASS_EN is defined, a same-cycle empty-buffer bypass.
module rca_result_buffer
   import rca_result_buffer_pkg::*;
#(
   parameter int DEPTH    = RCA_RESULT_BUF_DEPTH,
   parameter int WIDTH_RD = NUM_WRITE_PORTS * XLEN,
   localparam int CNT_W   = cnt_w(DEPTH)
) (
   input logic                clk,
   input logic                rst_n,
   rca_result_buffer_if.slave bus
);

   logic                full;
   logic                empty;
   id_t                 head_id;
   logic [WIDTH_RD-1:0] head_rd;
   logic [CNT_W-1:0]    fifo_count;
   logic                live;
   logic                bypass_hit;
   logic                push;
   logic                pop;

   // Handshakes are suppressed while in reset or flushing so nothing moves.
   assign live = rst_n && !bus.flush;

`ifdef RCA_RESULT_BYPASS_EN
   assign bypass_hit = live && empty && bus.res_valid;
   assign bus.wb_id  = bypass_hit ? bus.res_id : head_id;
   assign bus.wb_rd  = bypass_hit ? bus.res_rd : head_rd;
`else
   assign bypass_hit = 1'b0;
   assign bus.wb_id  = head_id;
   assign bus.wb_rd  = head_rd;
`endif

   assign bus.res_ready = live && !full;
   assign bus.wb_done   = live && (!empty || bypass_hit);
   assign bus.count     = fifo_count;

   // A bypassed result consumed in the same cycle never enters storage.
   assign push = bus.res_valid && bus.res_ready && !(bypass_hit && bus.wb_ack);
   assign pop  = bus.wb_done && bus.wb_ack && !empty;

   rca_result_fifo #(
      .DEPTH    (DEPTH),
      .WIDTH_RD (WIDTH_RD)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (bus.flush),
      .push    (push),
      .push_id (bus.res_id),
      .push_rd (bus.res_rd),
      .pop     (pop),
      .full    (full),
      .empty   (empty),
      .head_id (head_id),
      .head_rd (head_rd),
      .count   (fifo_count)
   );

endmodule
